// File: rtl/pcs_pkg.sv
// Shared PCS definitions: 66b sync-header encodings, header width and the
// receive block-lock state enum.
package pcs_pkg;

  localparam int unsigned HDR_W = 2;

  localparam logic [HDR_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [HDR_W-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2,
    ST_LOCKED    = 2'd3
  } block_lock_state_e;

  // Only the two transition patterns are legal sync headers.
  function automatic logic hdr_is_valid(input logic [HDR_W-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used by the optional block-lock statistics
// (present only when PCS_BLOCK_LOCK_STATS_EN is defined).
`ifdef PCS_BLOCK_LOCK_STATS_EN
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {WIDTH{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign o_count = count_q;

endmodule
`endif

// File: rtl/pcs_rx_block_lock.sv
// 64b/66b receive block-lock FSM: hunts for sync-header alignment with gearbox
// slips and monitors header errors once locked. Optional PCS_BLOCK_LOCK_STATS_EN.
module pcs_rx_block_lock
  import pcs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 64,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned ERR_LIMIT  = 16,
  parameter int unsigned SLIP_WAIT  = 33
) (
  input  logic             i_xver_rxc,
  input  logic             i_rx_reset_n,
  input  logic [HDR_W-1:0] i_header,
  input  logic             i_header_valid,
  output logic             o_slip,
  output logic             o_block_lock
`ifdef PCS_BLOCK_LOCK_STATS_EN
  ,
  output logic [15:0]      o_slip_count,
  output logic [15:0]      o_lock_loss_count
`endif
);

  localparam int unsigned CNT_W = $clog2(max4(LOCK_COUNT, WINDOW, ERR_LIMIT, SLIP_WAIT)) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LOCK_LIM = cnt_t'(LOCK_COUNT);
  localparam cnt_t WIN_LIM  = cnt_t'(WINDOW);
  localparam cnt_t ERR_LIM  = cnt_t'(ERR_LIMIT);
  localparam cnt_t WAIT_LIM = cnt_t'(SLIP_WAIT);

  block_lock_state_e state_q, state_d;
  cnt_t good_cnt_q, good_cnt_d;
  cnt_t wait_cnt_q, wait_cnt_d;
  cnt_t hdr_cnt_q,  hdr_cnt_d;
  cnt_t err_cnt_q,  err_cnt_d;
  logic slip_q, slip_d;
  logic lock_q, lock_d;

  logic hdr_ok;
  cnt_t good_inc, wait_inc, hdr_inc, err_inc;

  assign hdr_ok   = hdr_is_valid(i_header);
  assign good_inc = good_cnt_q + 1'b1;
  assign wait_inc = wait_cnt_q + 1'b1;
  assign hdr_inc  = hdr_cnt_q + 1'b1;
  assign err_inc  = err_cnt_q + {{(CNT_W-1){1'b0}}, ~hdr_ok};

  // NOTE: every signal gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    wait_cnt_d = wait_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      ST_UNLOCKED: begin
        if (i_header_valid) begin
          if (!hdr_ok) begin
            good_cnt_d = '0;
            state_d    = ST_SLIP;
          end else if (good_inc == LOCK_LIM) begin
            good_cnt_d = '0;
            hdr_cnt_d  = '0;
            err_cnt_d  = '0;
            state_d    = ST_LOCKED;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end

      // The slip pulse lasts one cycle whether or not a header arrives.
      ST_SLIP: begin
        wait_cnt_d = '0;
        state_d    = ST_SLIP_WAIT;
      end

      ST_SLIP_WAIT: begin
        if (i_header_valid) begin
          if (wait_inc == WAIT_LIM) begin
            wait_cnt_d = '0;
            good_cnt_d = '0;
            state_d    = ST_UNLOCKED;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
      end

      // Error limit is tested first so a window boundary cannot hide loss of lock.
      ST_LOCKED: begin
        if (i_header_valid) begin
          if (err_inc == ERR_LIM) begin
            hdr_cnt_d = '0;
            err_cnt_d = '0;
            state_d   = ST_SLIP;
          end else if (hdr_inc == WIN_LIM) begin
            hdr_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_inc;
            err_cnt_d = err_inc;
          end
        end
      end

      default: state_d = ST_UNLOCKED;
    endcase

    slip_d = (state_d == ST_SLIP);
    lock_d = (state_d == ST_LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_xver_rxc or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      state_q    <= ST_UNLOCKED;
      good_cnt_q <= '0;
      wait_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      err_cnt_q  <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      err_cnt_q  <= err_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;

`ifdef PCS_BLOCK_LOCK_STATS_EN
  logic lock_loss;
  assign lock_loss = (state_q == ST_LOCKED) && (state_d == ST_SLIP);

  sat_counter #(.WIDTH(16)) u_slip_cnt (
    .clk     (i_xver_rxc),
    .rst_n   (i_rx_reset_n),
    .i_inc   (slip_d),
    .o_count (o_slip_count)
  );

  sat_counter #(.WIDTH(16)) u_lock_loss_cnt (
    .clk     (i_xver_rxc),
    .rst_n   (i_rx_reset_n),
    .i_inc   (lock_loss),
    .o_count (o_lock_loss_count)
  );
`endif

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Self-checking bench for pcs_rx_block_lock: directed scenarios plus random
// header streams, compared every cycle against a behavioural lock model.
module tb_pcs_rx_block_lock;

  localparam int LOCK_COUNT = 64;
  localparam int WINDOW     = 64;
  localparam int ERR_LIMIT  = 16;
  localparam int SLIP_WAIT  = 33;

  logic       clk;
  logic       rst_n;
  logic [1:0] header;
  logic       header_valid;
  logic       slip;
  logic       block_lock;
`ifdef PCS_BLOCK_LOCK_STATS_EN
  logic [15:0] slip_count;
  logic [15:0] lock_loss_count;
`endif

  pcs_rx_block_lock dut (
    .i_xver_rxc        (clk),
    .i_rx_reset_n      (rst_n),
    .i_header          (header),
    .i_header_valid    (header_valid),
    .o_slip            (slip),
    .o_block_lock      (block_lock)
`ifdef PCS_BLOCK_LOCK_STATS_EN
    ,
    .o_slip_count      (slip_count),
    .o_lock_loss_count (lock_loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  // Behavioural model: lock flag, pending slip pulse, countdown of ignored
  // strobes, run length of good headers, and per-window header/error tallies.
  bit m_lock, m_slip;
  int m_ignore_left, m_run, m_seen, m_bad, m_slips, m_losses;

  function automatic bit legal(input logic [1:0] h);
    return h == 2'b01 || h == 2'b10;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_slip = 0; m_ignore_left = 0; m_run = 0;
    m_seen = 0; m_bad = 0; m_slips = 0; m_losses = 0;
  endtask

  task automatic model_step(input bit hv, input logic [1:0] h);
    if (m_slip) begin
      m_slip = 0;
      m_ignore_left = SLIP_WAIT;
    end else if (hv) begin
      if (m_ignore_left > 0) begin
        m_ignore_left--;
      end else if (!m_lock) begin
        if (legal(h)) begin
          m_run++;
          if (m_run == LOCK_COUNT) begin m_lock = 1; m_run = 0; m_seen = 0; m_bad = 0; end
        end else begin
          m_run = 0; m_slip = 1; m_slips++;
        end
      end else begin
        m_seen++;
        if (!legal(h)) m_bad++;
        if (m_bad == ERR_LIMIT) begin
          m_lock = 0; m_slip = 1; m_slips++; m_losses++; m_seen = 0; m_bad = 0;
        end else if (m_seen == WINDOW) begin
          m_seen = 0; m_bad = 0;
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic drive_cycle(input bit hv, input logic [1:0] h);
    header_valid = hv;
    header       = h;
    @(posedge clk);
    model_step(hv, h);
    @(negedge clk);
    check("slip", slip, m_slip);
    check("block_lock", block_lock, m_lock);
`ifdef PCS_BLOCK_LOCK_STATS_EN
    check("slip_count", slip_count, m_slips);
    check("lock_loss_count", lock_loss_count, m_losses);
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    header_valid = 1'b0;
    header = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_slip", slip, 1'b0);
    check("rst_lock", block_lock, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] rand_valid();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rand_invalid();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic acquire_lock();
    for (int i = 0; i < LOCK_COUNT; i++) drive_cycle(1'b1, rand_valid());
  endtask

  task automatic ride_out_slip();
    drive_cycle(1'b1, rand_invalid());
    for (int i = 0; i < SLIP_WAIT; i++) drive_cycle(1'b1, rand_invalid());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int slip_seen;
    int gaps;
    int strobes;
    int err_pct;
    rst_n = 1'b0;
    header = 2'b00;
    header_valid = 1'b0;
    @(negedge clk);
    apply_reset();

    // Initial lock on 64 data headers; no slip may appear.
    slip_seen = 0;
    for (int i = 0; i < LOCK_COUNT; i++) begin
      if (i == LOCK_COUNT - 1) check("pre_lock", block_lock, 1'b0);
      drive_cycle(1'b1, 2'b01);
      slip_seen += int'(slip);
    end
    check("lock_after_64", block_lock, 1'b1);
    check("no_slip_during_hunt", slip_seen, 0);

    // Hunt interrupted by a bad header, then 33 ignored strobes, then relock.
    apply_reset();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, rand_valid());
    drive_cycle(1'b1, 2'b11);
    check("slip_pulse", slip, 1'b1);
    drive_cycle(1'b1, 2'b00);
    check("slip_one_cycle", slip, 1'b0);
    for (int i = 0; i < SLIP_WAIT; i++)
      drive_cycle(1'b1, ($urandom_range(0, 2) == 0) ? rand_invalid() : rand_valid());
    check("no_slip_in_wait", slip, 1'b0);
    for (int i = 0; i < LOCK_COUNT - 1; i++) drive_cycle(1'b1, rand_valid());
    check("relock_pending", block_lock, 1'b0);
    drive_cycle(1'b1, rand_valid());
    check("relock", block_lock, 1'b1);

    // 15 errors in one window hold lock; 16 in the next drop it.
    for (int i = 0; i < WINDOW; i++)
      drive_cycle(1'b1, (i % 4 == 0 && i < 60) ? rand_invalid() : rand_valid());
    check("lock_held_15_err", block_lock, 1'b1);
    for (int i = 0; i < ERR_LIMIT; i++) drive_cycle(1'b1, rand_invalid());
    check("lock_lost_16_err", block_lock, 1'b0);
    check("slip_on_loss", slip, 1'b1);

    // 16th error on the 64th header of a window: loss must win over window clear.
    ride_out_slip();
    acquire_lock();
    check("lock_before_edge_case", block_lock, 1'b1);
    for (int i = 0; i < WINDOW - ERR_LIMIT; i++) drive_cycle(1'b1, rand_valid());
    for (int i = 0; i < ERR_LIMIT - 1; i++) drive_cycle(1'b1, rand_invalid());
    check("lock_at_header_63", block_lock, 1'b1);
    drive_cycle(1'b1, rand_invalid());
    check("lock_lost_at_64", block_lock, 1'b0);
    check("slip_at_64", slip, 1'b1);

    // Valid-gaps every 33 cycles carrying an illegal header must not count.
    apply_reset();
    strobes = 0;
    gaps = 0;
    for (int c = 0; strobes < LOCK_COUNT; c++) begin
      if (c % 33 == 32) begin
        drive_cycle(1'b0, 2'b11);
        gaps++;
      end else begin
        if (strobes == LOCK_COUNT - 1) check("gap_pre_lock", block_lock, 1'b0);
        drive_cycle(1'b1, 2'b10);
        strobes++;
      end
    end
    check("gap_lock", block_lock, 1'b1);
    check("gap_count", gaps, 1);

    // Asynchronous reset while locked.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_lock", block_lock, 1'b0);
    check("async_rst_slip", slip, 1'b0);
`ifdef PCS_BLOCK_LOCK_STATS_EN
    check("async_rst_slip_count", slip_count, 0);
    check("async_rst_loss_count", lock_loss_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LOCK_COUNT - 1; i++) drive_cycle(1'b1, rand_valid());
    check("post_rst_pending", block_lock, 1'b0);
    drive_cycle(1'b1, rand_valid());
    check("post_rst_lock", block_lock, 1'b1);

    // Random segments with varying error rate and strobe gaps.
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 3))
        0:       err_pct = 0;
        1:       err_pct = 3;
        2:       err_pct = 25;
        default: err_pct = 50;
      endcase
      for (int i = 0; i < 200; i++)
        drive_cycle($urandom_range(0, 7) != 0,
                    ($urandom_range(0, 99) < err_pct) ? rand_invalid() : rand_valid());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
